// File: rtl/ask_slicer_adaptive.sv
// Adaptive ASK decision slicer: peak/trough envelope tracking, midpoint threshold,
// hysteresis comparator with consecutive-sample debounce, lock detection.
module ask_slicer_adaptive #(
    parameter int IO_WIDTH    = 14,
    parameter int HYST        = 200,
    parameter int DEBOUNCE    = 4,
    parameter int DECAY_SHIFT = 10,
    parameter int MIN_SWING   = 500,
    parameter int OUT_HI      = 5500,
    parameter int OUT_LO      = 100,
    parameter int INVERT      = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din_valid,
    input  logic signed [IO_WIDTH-1:0] din,
    output logic signed [IO_WIDTH-1:0] ask_out,
    output logic                       bit_out,
    output logic                       bit_edge,
    output logic signed [IO_WIDTH-1:0] thr_out,
    output logic                       lock
);

    localparam int W2 = IO_WIDTH + 2;
    localparam logic signed [W2-1:0]       HYST_W   = W2'(HYST);
    localparam logic signed [W2-1:0]       LOCK_W   = W2'(MIN_SWING);
    localparam logic signed [W2-1:0]       UNLOCK_W = W2'(MIN_SWING / 2);
    localparam logic [7:0]                 DEB_W    = 8'(DEBOUNCE);
    localparam logic signed [IO_WIDTH-1:0] HI_V     = IO_WIDTH'(OUT_HI);
    localparam logic signed [IO_WIDTH-1:0] LO_V     = IO_WIDTH'(OUT_LO);
    localparam logic                       INV      = (INVERT != 0);

    typedef enum logic [1:0] {ST_INIT, ST_TRACK, ST_LOCKED} state_t;

    state_t                      state;
    logic signed [IO_WIDTH-1:0]  x_r;
    logic                        v_r;
    logic signed [W2-1:0]        pk, tr;
    logic                        s;
    logic [7:0]                  cnt;

    logic signed [W2-1:0] x_w, diff, dec, sum_old, thr_old;
    logic signed [W2-1:0] pk_n, tr_n, swing_n, sum_n, thr_n;
    logic [7:0]           cnt_inc;
    logic                 qual, s_gt, bit_lock;
    logic                 unused_bits;

    assign x_w     = {{2{x_r[IO_WIDTH-1]}}, x_r};
    assign diff    = pk - tr;
    assign dec     = diff >>> DECAY_SHIFT;
    assign sum_old = pk + tr;
    assign thr_old = sum_old >>> 1;

    // Leak toward each other unless the new sample extends the envelope.
    assign pk_n    = (x_w > pk) ? x_w : pk - dec;
    assign tr_n    = (x_w < tr) ? x_w : tr + dec;
    assign swing_n = pk_n - tr_n;
    assign sum_n   = pk_n + tr_n;
    assign thr_n   = sum_n >>> 1;

    // NOTE: the decision compares against the threshold before this sample's envelope update.
    assign qual     = s ? (x_w < thr_old - HYST_W) : (x_w > thr_old + HYST_W);
    assign s_gt     = (x_w > thr_n);
    assign bit_lock = s_gt ^ INV;
    assign cnt_inc  = cnt + 8'd1;

    assign unused_bits = ^thr_n[W2-1:IO_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r <= '0;
            v_r <= 1'b0;
        end else begin
            v_r <= din_valid;
            if (din_valid) x_r <= din;
        end
    end

    // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            pk       <= '0;
            tr       <= '0;
            s        <= 1'b0;
            cnt      <= '0;
            lock     <= 1'b0;
            bit_out  <= 1'b0;
            bit_edge <= 1'b0;
            ask_out  <= LO_V;
            thr_out  <= '0;
        end else if (v_r) begin
            bit_edge <= 1'b0;
            case (state)
                ST_INIT: begin
                    pk      <= x_w;
                    tr      <= x_w;
                    thr_out <= x_r;
                    state   <= ST_TRACK;
                end
                ST_TRACK: begin
                    pk      <= pk_n;
                    tr      <= tr_n;
                    thr_out <= thr_n[IO_WIDTH-1:0];
                    if (swing_n >= LOCK_W) begin
                        state    <= ST_LOCKED;
                        lock     <= 1'b1;
                        s        <= s_gt;
                        cnt      <= '0;
                        bit_out  <= bit_lock;
                        bit_edge <= bit_lock;
                        ask_out  <= bit_lock ? HI_V : LO_V;
                    end
                end
                ST_LOCKED: begin
                    pk      <= pk_n;
                    tr      <= tr_n;
                    thr_out <= thr_n[IO_WIDTH-1:0];
                    if (swing_n < UNLOCK_W) begin
                        state    <= ST_TRACK;
                        lock     <= 1'b0;
                        s        <= 1'b0;
                        cnt      <= '0;
                        bit_out  <= 1'b0;
                        bit_edge <= bit_out;
                        ask_out  <= LO_V;
                    end else if (qual) begin
                        if (cnt_inc == DEB_W) begin
                            s        <= ~s;
                            cnt      <= '0;
                            bit_out  <= ~bit_out;
                            bit_edge <= 1'b1;
                            ask_out  <= bit_out ? LO_V : HI_V;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end else begin
            bit_edge <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ask_slicer_adaptive.sv
// Scoreboard bench for ask_slicer_adaptive: three instances (default, fast decay,
// non-inverted single-sample debounce) driven in turn with directed vectors.
module tb_ask_slicer_adaptive;

    localparam int M_LOCK = 1;
    localparam int M_BIT  = 2;
    localparam int M_ASK  = 4;
    localparam int M_THR  = 8;
    localparam int M_EDGE = 16;
    localparam int M_ALL  = 31;
    localparam int M_NOTH = 23;

    typedef struct {
        int   dut;
        int   idx;
        int   mask;
        logic e_lock;
        logic e_bit;
        logic e_edge;
        int   e_thr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic              din_valid [3];
    logic signed [13:0] din      [3];
    logic signed [13:0] ask_o    [3];
    logic signed [13:0] thr_o    [3];
    logic              bit_o    [3];
    logic              edge_o   [3];
    logic              lock_o   [3];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   sample_no = 0;
    bit   p1 [3];
    bit   p2 [3];
    exp_t e_mon;

    always #5 clk = ~clk;

    ask_slicer_adaptive u0 (
        .clk(clk), .rst(rst), .din_valid(din_valid[0]), .din(din[0]),
        .ask_out(ask_o[0]), .bit_out(bit_o[0]), .bit_edge(edge_o[0]),
        .thr_out(thr_o[0]), .lock(lock_o[0])
    );

    ask_slicer_adaptive #(.DECAY_SHIFT(4)) u1 (
        .clk(clk), .rst(rst), .din_valid(din_valid[1]), .din(din[1]),
        .ask_out(ask_o[1]), .bit_out(bit_o[1]), .bit_edge(edge_o[1]),
        .thr_out(thr_o[1]), .lock(lock_o[1])
    );

    ask_slicer_adaptive #(.INVERT(0), .DEBOUNCE(1)) u2 (
        .clk(clk), .rst(rst), .din_valid(din_valid[2]), .din(din[2]),
        .ask_out(ask_o[2]), .bit_out(bit_o[2]), .bit_edge(edge_o[2]),
        .thr_out(thr_o[2]), .lock(lock_o[2])
    );

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (sample %0d): got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Outputs reflect a sample two edges after its din_valid cycle.
    initial begin
        for (int d = 0; d < 3; d++) begin
            p1[d] = 1'b0;
            p2[d] = 1'b0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 3; d++) begin
                p2[d] = p1[d];
                p1[d] = din_valid[d] && !rst;
            end
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (p2[d] && !rst) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL scoreboard_underflow: dut %0d presented output, expected none", d);
                    end else begin
                        e_mon = sb.pop_front();
                        check("dut_id", e_mon.idx, d, e_mon.dut);
                        if ((e_mon.mask & M_LOCK) != 0) check("lock", e_mon.idx, int'(lock_o[d]), int'(e_mon.e_lock));
                        if ((e_mon.mask & M_BIT) != 0)  check("bit_out", e_mon.idx, int'(bit_o[d]), int'(e_mon.e_bit));
                        if ((e_mon.mask & M_ASK) != 0)  check("ask_out", e_mon.idx, int'(ask_o[d]), e_mon.e_bit ? 5500 : 100);
                        if ((e_mon.mask & M_THR) != 0)  check("thr_out", e_mon.idx, int'(thr_o[d]), e_mon.e_thr);
                        if ((e_mon.mask & M_EDGE) != 0) check("bit_edge", e_mon.idx, int'(edge_o[d]), int'(e_mon.e_edge));
                    end
                end
            end
        end
    end

    task automatic send(input int d, input int x, input int mask,
                        input logic el, input logic eb, input logic ee, input int et);
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < 3; k++) din_valid[k] = 1'b0;
        din[d]       = 14'(x);
        din_valid[d] = 1'b1;
        sample_no++;
        e.dut    = d;
        e.idx    = sample_no;
        e.mask   = mask;
        e.e_lock = el;
        e.e_bit  = eb;
        e.e_edge = ee;
        e.e_thr  = et;
        sb.push_back(e);
    endtask

    task automatic drain();
        int budget;
        @(negedge clk);
        for (int k = 0; k < 3; k++) din_valid[k] = 1'b0;
        budget = 10;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_state(input int d, input string tag);
        check({tag, "_ask_out"}, d, int'(ask_o[d]), 100);
        check({tag, "_bit_out"}, d, int'(bit_o[d]), 0);
        check({tag, "_bit_edge"}, d, int'(edge_o[d]), 0);
        check({tag, "_lock"}, d, int'(lock_o[d]), 0);
        check({tag, "_thr_out"}, d, int'(thr_o[d]), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            din_valid[d] = 1'b0;
            din[d]       = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) check_reset_state(d, "por");
        rst = 1'b0;

        // Default instance: lock on the first 6000, then slicing with 4-sample debounce.
        sample_no = 0;
        for (int i = 1; i <= 20; i++) send(0, 1000, M_ALL, 1'b0, 1'b0, 1'b0, 1000);
        send(0, 6000, M_ALL, 1'b1, 1'b0, 1'b0, 3500);
        send(0, 6000, M_ALL, 1'b1, 1'b0, 1'b0, 3500);
        for (int i = 23; i <= 40; i++) send(0, 6000, M_NOTH, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 41; i <= 60; i++) send(0, 1000, M_NOTH, 1'b1, (i >= 44), (i == 44), 0);
        // Isolated high glitches while sliced low must not flip the bit.
        for (int g = 0; g < 6; g++) send(0, (g % 2 == 0) ? 6000 : 1000, M_NOTH, 1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) send(0, 1000, M_NOTH, 1'b1, 1'b1, 1'b0, 0);
        drain();

        // Asynchronous reset while locked, asserted between clock edges.
        @(posedge clk);
        #2;
        check("pre_reset_lock", 0, int'(lock_o[0]), 1);
        rst = 1'b1;
        #1;
        check_reset_state(0, "async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Re-initialisation, then hysteresis edges around thr-HYST = 3300.
        sample_no = 0;
        send(0, 1000, M_ALL, 1'b0, 1'b0, 1'b0, 1000);
        for (int i = 2; i <= 20; i++) send(0, 1000, M_ALL, 1'b0, 1'b0, 1'b0, 1000);
        send(0, 6000, M_ALL, 1'b1, 1'b0, 1'b0, 3500);
        send(0, 6000, M_ALL, 1'b1, 1'b0, 1'b0, 3500);
        for (int i = 0; i < 50; i++) send(0, 3400, M_ALL, 1'b1, 1'b0, 1'b0, 3500);
        for (int i = 0; i < 3; i++)  send(0, 3299, M_ALL, 1'b1, 1'b0, 1'b0, 3500);
        send(0, 3300, M_ALL, 1'b1, 1'b0, 1'b0, 3500);
        for (int i = 0; i < 3; i++)  send(0, 3299, M_ALL, 1'b1, 1'b0, 1'b0, 3500);
        send(0, 3299, M_ALL, 1'b1, 1'b1, 1'b1, 3500);
        drain();

        // Fast-decay instance: lock, lose lock on a flat envelope, re-lock.
        sample_no = 0;
        for (int i = 1; i <= 20; i++) send(1, 1000, M_ALL, 1'b0, 1'b0, 1'b0, 1000);
        send(1, 6000, M_ALL, 1'b1, 1'b0, 1'b0, 3500);
        for (int i = 22; i <= 40; i++) send(1, 6000, M_LOCK, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 41; i <= 60; i++) send(1, 1000, M_LOCK, 1'b1, 1'b0, 1'b0, 0);
        send(1, 3500, M_LOCK, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 2; i <= 39; i++) send(1, 3500, 0, 1'b0, 1'b0, 1'b0, 0);
        send(1, 3500, M_LOCK | M_BIT | M_ASK, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 19; i++) send(1, 1000, 0, 1'b0, 1'b0, 1'b0, 0);
        send(1, 1000, M_LOCK, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 19; i++) send(1, 6000, 0, 1'b0, 1'b0, 1'b0, 0);
        send(1, 6000, M_LOCK, 1'b1, 1'b0, 1'b0, 0);
        drain();

        // Non-inverted, single-sample debounce: bit follows the envelope.
        sample_no = 0;
        for (int i = 1; i <= 20; i++) send(2, 1000, M_ALL, 1'b0, 1'b0, 1'b0, 1000);
        send(2, 6000, M_ALL, 1'b1, 1'b1, 1'b1, 3500);
        for (int i = 22; i <= 40; i++) send(2, 6000, M_NOTH, 1'b1, 1'b1, 1'b0, 0);
        for (int i = 41; i <= 60; i++) send(2, 1000, M_NOTH, 1'b1, 1'b0, (i == 41), 0);
        for (int i = 61; i <= 80; i++) send(2, 6000, M_NOTH, 1'b1, 1'b1, (i == 61), 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
